// File: rtl/tt_response_checker.sv
// Response checker for an exhaustive N_IN-input stimulus sweep: collects
// (vector, f) samples, builds the observed truth table and grades it.
module tt_response_checker #(
    parameter int                    N_IN     = 4,
    parameter logic [2**N_IN-1:0]    EXPECTED = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [N_IN-1:0]      in_vec,
    input  logic                 in_f,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 mismatch,
    output logic                 dup,
    output logic [2**N_IN-1:0]   table_out,
    output logic [N_IN:0]        seen_cnt,
    output logic [N_IN:0]        err_cnt,
    output logic [N_IN-1:0]      first_err_idx
);

    localparam int NV = 2**N_IN;
    localparam logic [N_IN:0] LAST_CNT = (N_IN+1)'(NV - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [NV-1:0]   seen_q;
    logic            accept;
    logic            is_new;
    logic            is_bad;

    // start wins over a same-cycle sample, so it blocks the accept
    assign accept = in_valid && in_ready && !start;
    assign is_new = !seen_q[in_vec];
    assign is_bad = in_f != EXPECTED[in_vec];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = COLLECT;
            end
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (start) begin
                    state_d = COLLECT;
                end else if (accept && is_new && seen_cnt == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = COLLECT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pass = done && (err_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst || start) begin
            seen_q        <= '0;
            table_out     <= '0;
            seen_cnt      <= '0;
            err_cnt       <= '0;
            mismatch      <= 1'b0;
            dup           <= 1'b0;
            first_err_idx <= '0;
        end else if (accept) begin
            if (is_new) begin
                seen_q[in_vec]    <= 1'b1;
                table_out[in_vec] <= in_f;
                seen_cnt          <= seen_cnt + 1'b1;
                if (is_bad) begin
                    err_cnt  <= err_cnt + 1'b1;
                    mismatch <= 1'b1;
                    if (err_cnt == '0) first_err_idx <= in_vec;
                end
            end else begin
                dup <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tt_response_checker.sv
// Bench for tt_response_checker: 4-input AND golden table, directed sweeps
// checked every cycle against a sample-list model plus literal pins.
module tb_tt_response_checker;

    localparam logic [15:0] EXP = 16'h8000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_vec = '0;
    logic        in_f = 1'b0;
    logic        in_ready, busy, done, pass, mismatch, dup;
    logic [15:0] table_out;
    logic [4:0]  seen_cnt, err_cnt;
    logic [3:0]  first_err_idx;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    tt_response_checker #(.N_IN(4), .EXPECTED(EXP)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_vec(in_vec), .in_f(in_f),
        .in_ready(in_ready), .busy(busy), .done(done), .pass(pass),
        .mismatch(mismatch), .dup(dup), .table_out(table_out),
        .seen_cnt(seen_cnt), .err_cnt(err_cnt),
        .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    // Model: phase (0 idle, 1 collect, 2 done) and the list of samples
    // accepted since the last start; results are derived from the list.
    int       phase = 0;
    int       q_vec[$];
    bit       q_f[$];

    int          m_cnt, m_err, m_fe;
    bit          m_mm, m_dup;
    logic [15:0] m_tab;

    function automatic void evaluate();
        bit seen[16];
        foreach (seen[k]) seen[k] = 0;
        m_cnt = 0; m_err = 0; m_fe = 0;
        m_mm = 0; m_dup = 0; m_tab = '0;
        foreach (q_vec[k]) begin
            int v;
            v = q_vec[k];
            if (seen[v]) begin
                m_dup = 1;
            end else begin
                seen[v] = 1;
                m_tab[v] = q_f[k];
                m_cnt++;
                if (q_f[k] != EXP[v]) begin
                    if (m_err == 0) m_fe = v;
                    m_err++;
                    m_mm = 1;
                end
            end
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            phase = 0;
            q_vec.delete();
            q_f.delete();
        end else if (start) begin
            phase = 1;
            q_vec.delete();
            q_f.delete();
        end else if (phase == 1 && in_valid) begin
            q_vec.push_back(int'(in_vec));
            q_f.push_back(in_f);
            evaluate();
            if (m_cnt == 16) phase = 2;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s @%0t: got %0h, expected %0h",
                         name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            evaluate();
            check("in_ready", 32'(in_ready), 32'(phase == 1));
            check("busy", 32'(busy), 32'(phase == 1));
            check("done", 32'(done), 32'(phase == 2));
            check("pass", 32'(pass), 32'(phase == 2 && m_err == 0));
            check("mismatch", 32'(mismatch), 32'(m_mm));
            check("dup", 32'(dup), 32'(m_dup));
            check("table_out", 32'(table_out), 32'(m_tab));
            check("seen_cnt", 32'(seen_cnt), 32'(m_cnt));
            check("err_cnt", 32'(err_cnt), 32'(m_err));
            check("first_err_idx", 32'(first_err_idx), 32'(m_fe));
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input int v, input bit f);
        in_valid = 1'b1;
        in_vec   = 4'(v);
        in_f     = f;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic sweep(input int bad, input int skip, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            bit f;
            if (i != skip) begin
                f = (i == 15);
                if (i == bad) f = ~f;
                if (gaps) repeat ($urandom_range(0, 2)) cyc();
                send(i, f);
            end
        end
    endtask

    initial begin
        // 1: reset
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_table", 32'(table_out), 32'd0);
        check("rst_seen", 32'(seen_cnt), 32'd0);

        // 2: clean ordered sweep
        pulse_start();
        sweep(-1, -1, 1'b0);
        check("t2_done", 32'(done), 32'd1);
        check("t2_pass", 32'(pass), 32'd1);
        check("t2_table", 32'(table_out), 32'h8000);
        check("t2_err", 32'(err_cnt), 32'd0);
        cyc();

        // 3: vector 5 wrong
        pulse_start();
        sweep(5, -1, 1'b0);
        check("t3_pass", 32'(pass), 32'd0);
        check("t3_mm", 32'(mismatch), 32'd1);
        check("t3_err", 32'(err_cnt), 32'd1);
        check("t3_first", 32'(first_err_idx), 32'd5);
        check("t3_table", 32'(table_out), 32'h8020);

        // 4: duplicate of vector 3, first sample wins
        pulse_start();
        send(3, 1'b0);
        send(3, 1'b1);
        sweep(-1, 3, 1'b0);
        check("t4_dup", 32'(dup), 32'd1);
        check("t4_seen", 32'(seen_cnt), 32'd16);
        check("t4_tab3", 32'(table_out[3]), 32'd0);
        check("t4_pass", 32'(pass), 32'd1);

        // 5: valid ignored in DONE and IDLE, then gapped reverse-free sweep
        send(7, 1'b1);
        check("t5_done_seen", 32'(seen_cnt), 32'd16);
        check("t5_done_tab", 32'(table_out), 32'h8000);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        send(15, 1'b1);
        check("t5_idle_seen", 32'(seen_cnt), 32'd0);
        check("t5_idle_tab", 32'(table_out), 32'd0);
        pulse_start();
        sweep(-1, -1, 1'b1);
        check("t5_gap_pass", 32'(pass), 32'd1);
        check("t5_gap_tab", 32'(table_out), 32'h8000);

        // 6: restart mid-collect, start beats same-cycle sample
        pulse_start();
        for (int i = 8; i < 15; i++) send(i, 1'b1);
        check("t6_mid_err", 32'(err_cnt), 32'd7);
        start = 1'b1;
        in_valid = 1'b1;
        in_vec = 4'd2;
        in_f = 1'b1;
        cyc();
        start = 1'b0;
        in_valid = 1'b0;
        check("t6_clr_seen", 32'(seen_cnt), 32'd0);
        check("t6_clr_tab", 32'(table_out), 32'd0);
        sweep(-1, -1, 1'b0);
        check("t6_pass", 32'(pass), 32'd1);
        pulse_start();
        for (int i = 0; i < 5; i++) send(i, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_mm", 32'(mismatch), 32'd0);
        check("t6_rst_seen", 32'(seen_cnt), 32'd0);
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
